// File: rtl/cache_set_plru_part_if.sv
// Request/response and domain-switch bus of the partitioned tree-PLRU tag store.
// The slave modport is used by the tag store and the master modport by its requester.
interface cache_set_plru_part_if #(
    parameter int NUM_WAYS  = 8,
    parameter int NUM_SETS  = 4,
    parameter int TAG_WIDTH = 16
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;

    logic                 os_req;
    logic [NUM_WAYS-1:0]  os_hitmap;
    logic                 os_flush;
    logic                 req_valid;
    logic                 req_ready;
    logic [SET_W-1:0]     req_set;
    logic [TAG_WIDTH-1:0] req_tag;
    logic                 resp_valid;
    logic                 resp_hit;
    logic [WAY_W-1:0]     resp_way;
    logic                 busy;

    modport slave (
        input  os_req, os_hitmap, os_flush, req_valid, req_set, req_tag,
        output req_ready, resp_valid, resp_hit, resp_way, busy
    );

    modport master (
        output os_req, os_hitmap, os_flush, req_valid, req_set, req_tag,
        input  req_ready, resp_valid, resp_hit, resp_way, busy
    );
endinterface

// File: rtl/cache_set_plru_part.sv
// Set-associative tag store with way-partitioned tree-PLRU replacement and flush sweep.
// Optional macro PLRU_INVALID_FIRST_EN: a miss prefers the lowest allowed invalid way.
//
// state   | meaning
// S_IDLE  | accepting lookups and domain switches
// S_FLUSH | scrubbing the outgoing domain, one set per cycle
module cache_set_plru_part #(
    parameter int NUM_WAYS  = 8,
    parameter int NUM_SETS  = 4,
    parameter int TAG_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cache_set_plru_part_if.slave  bus
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SET_W-1:0]     r_sweep;
    logic [NUM_WAYS-1:0]  r_hitmap;
    logic [NUM_WAYS-1:0]  r_old_mask;

    logic [TAG_WIDTH-1:0] r_tag   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]  r_valid [NUM_SETS];
    logic [NUM_WAYS-1:1]  r_plru  [NUM_SETS];

    logic                 r_resp_valid;
    logic                 r_resp_hit;
    logic [WAY_W-1:0]     r_resp_way;

    logic                 w_ready;
    logic                 w_busy;
    logic                 w_accept;
    logic                 w_lookup;
    logic [NUM_WAYS-1:0]  w_valid_set;
    logic [NUM_WAYS-1:1]  w_plru_set;
    logic [NUM_WAYS-1:1]  w_plru_new;
    logic [NUM_WAYS-1:1]  w_lo_any;
    logic [NUM_WAYS-1:1]  w_hi_any;
    logic [NUM_WAYS-1:1]  w_masked;
    logic                 w_hit;
    logic [WAY_W-1:0]     w_hit_way;
    logic [WAY_W-1:0]     w_tree_victim;
    logic [WAY_W-1:0]     w_victim;
    logic [WAY_W-1:0]     w_upd_way;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = !bus.os_req;
                if (bus.os_req && bus.os_flush) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_busy = 1'b1;
                if (r_sweep == LAST_SET) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.req_ready = w_ready && reset_n;
    assign bus.busy      = w_busy;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_lookup      = w_accept && (|r_hitmap);

    // ------------------------------------------------- partition / control
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hitmap   <= '0;
            r_old_mask <= '0;
            r_sweep    <= '0;
        end else if (r_state == S_IDLE) begin
            if (bus.os_req) begin
                r_hitmap <= bus.os_hitmap;
                if (bus.os_flush) begin
                    r_old_mask <= r_hitmap;
                    r_sweep    <= '0;
                end
            end
        end else begin
            r_sweep <= r_sweep + 1'b1;
        end
    end

    // Per-node subtree occupancy of the partition; fixed by the tree shape.
    for (genvar n = 1; n < NUM_WAYS; n++) begin : g_node
        localparam int D  = $clog2(n + 1) - 1;
        localparam int SZ = NUM_WAYS >> D;
        localparam int LO = (n - (1 << D)) * SZ;
        assign w_lo_any[n] = |r_hitmap[LO +: SZ/2];
        assign w_hi_any[n] = |r_hitmap[LO + SZ/2 +: SZ/2];
    end

    assign w_masked    = ~(w_lo_any & w_hi_any);
    assign w_valid_set = r_valid[bus.req_set];
    assign w_plru_set  = r_plru[bus.req_set];

    // --------------------------------------------------------------- hit
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (w_valid_set[i] && r_hitmap[i] &&
                (r_tag[bus.req_set][i] == bus.req_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(i);
            end
        end
    end

    // ------------------------------------------------------ victim walk
    always_comb begin
        logic [WAY_W-1:0] v_node;
        logic             v_go;
        v_node        = WAY_W'(1);
        v_go          = 1'b0;
        w_tree_victim = '0;
        for (int d = 0; d < WAY_W; d++) begin
            v_go          = w_masked[v_node] ? w_hi_any[v_node] : w_plru_set[v_node];
            w_tree_victim = (w_tree_victim << 1) | WAY_W'(v_go);
            v_node        = (v_node << 1) | WAY_W'(v_go);
        end
    end

`ifdef PLRU_INVALID_FIRST_EN
    logic [NUM_WAYS-1:0] w_inv;
    logic                w_inv_found;
    logic [WAY_W-1:0]    w_inv_way;

    always_comb begin
        w_inv       = r_hitmap & ~w_valid_set;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (w_inv[i]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(i);
            end
        end
    end

    assign w_victim = w_inv_found ? w_inv_way : w_tree_victim;
`else
    assign w_victim = w_tree_victim;
`endif

    assign w_upd_way = w_hit ? w_hit_way : w_victim;

    // Point every unmasked node on the touched way's path away from it.
    always_comb begin
        logic [WAY_W-1:0] v_node;
        logic             v_go;
        v_node     = WAY_W'(1);
        v_go       = 1'b0;
        w_plru_new = w_plru_set;
        for (int d = 0; d < WAY_W; d++) begin
            v_go = w_upd_way[WAY_W-1-d];
            if (!w_masked[v_node]) begin
                w_plru_new[v_node] = !v_go;
            end
            v_node = (v_node << 1) | WAY_W'(v_go);
        end
    end

    // ------------------------------------------------------- tag storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_tag[s][w] <= '0;
                end
            end
        end else if (r_state == S_FLUSH) begin
            r_valid[r_sweep] <= r_valid[r_sweep] & ~r_old_mask;
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (r_old_mask[w]) begin
                    r_tag[r_sweep][w] <= '0;
                end
            end
        end else if (w_lookup) begin
            r_plru[bus.req_set] <= w_plru_new;
            if (!w_hit) begin
                r_tag[bus.req_set][w_victim]   <= bus.req_tag;
                r_valid[bus.req_set][w_victim] <= 1'b1;
            end
        end
    end

    // --------------------------------------------------------- response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_way   <= '0;
        end else begin
            r_resp_valid <= w_accept;
            if (w_accept) begin
                r_resp_hit <= w_hit;
                r_resp_way <= (|r_hitmap) ? w_upd_way : '0;
            end
        end
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_hit   = r_resp_hit;
    assign bus.resp_way   = r_resp_way;
endmodule
